// File: rtl/pattern_detector.sv
// ============================================================================
// Module   : pattern_detector
// Brief    : Serial pattern matcher with match counter and lock-on-halt FSM.
//            Optional macro PATTERN_MASK_EN adds a per-bit compare mask.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pattern_detector #(
  parameter int WIDTH      = 8,
  parameter int CNT_W      = 8,
  parameter int HALT_LIMIT = 200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_in,
  input  logic             data_valid,
  input  logic [WIDTH-1:0] pattern,
`ifdef PATTERN_MASK_EN
  input  logic [WIDTH-1:0] pattern_mask,
`endif
  input  logic             enable_count,
  input  logic [1:0]       ctrl_state,
  output logic             match_flag,
  output logic             halt_flag,
  output logic [CNT_W-1:0] match_count
);

  localparam int FILL_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [FILL_W-1:0] c_FILL_LAST = FILL_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  c_CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  c_HALT      = CNT_W'(HALT_LIMIT);

  typedef enum logic [1:0] {
    ST_FILL   = 2'b00,
    ST_SCAN   = 2'b01,
    ST_LOCKED = 2'b10
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [WIDTH-1:0]  r_window, w_window_nxt, w_window_shift;
  logic [FILL_W-1:0] r_fill_cnt, w_fill_nxt;
  logic              r_match, w_match_nxt;
  logic              r_halt, w_halt_nxt;
  logic [CNT_W-1:0]  r_count, w_count_nxt, w_count_inc;
  logic              w_match;
  logic              w_illegal;

  assign w_window_shift = {r_window[WIDTH-2:0], data_in};
  assign w_count_inc    = r_count + 1'b1;
  assign w_illegal      = (ctrl_state == 2'b11);

`ifdef PATTERN_MASK_EN
  assign w_match = (((w_window_shift ^ pattern) & pattern_mask) == '0);
`else
  assign w_match = (w_window_shift == pattern);
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_window_nxt = r_window;
    w_fill_nxt   = r_fill_cnt;
    w_match_nxt  = r_match;
    w_halt_nxt   = r_halt;
    w_count_nxt  = r_count;
    case (r_state)
      ST_FILL: begin
        // Illegal controller state locks before any shift or match update
        if (w_illegal) begin
          w_state_nxt = ST_LOCKED;
          w_halt_nxt  = 1'b1;
          w_match_nxt = 1'b0;
        end else if (data_valid) begin
          w_window_nxt = w_window_shift;
          if (r_fill_cnt == c_FILL_LAST) begin
            w_state_nxt = ST_SCAN;
            w_match_nxt = w_match;
          end else begin
            w_fill_nxt = r_fill_cnt + 1'b1;
          end
        end
      end
      ST_SCAN: begin
        if (w_illegal) begin
          w_state_nxt = ST_LOCKED;
          w_halt_nxt  = 1'b1;
          w_match_nxt = 1'b0;
        end else if (data_valid) begin
          w_window_nxt = w_window_shift;
          w_match_nxt  = w_match;
          if (enable_count && (r_count != c_CNT_MAX)) begin
            w_count_nxt = w_count_inc;
            // Reaching the limit locks and suppresses a coincident match
            if (w_count_inc == c_HALT) begin
              w_state_nxt = ST_LOCKED;
              w_halt_nxt  = 1'b1;
              w_match_nxt = 1'b0;
            end
          end
        end
      end
      ST_LOCKED: begin
        w_halt_nxt  = 1'b1;
        w_match_nxt = 1'b0;
      end
      default: begin
        w_state_nxt  = ST_FILL;
        w_window_nxt = '0;
        w_fill_nxt   = '0;
        w_match_nxt  = 1'b0;
        w_halt_nxt   = 1'b0;
        w_count_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_FILL;
      r_window   <= '0;
      r_fill_cnt <= '0;
      r_match    <= 1'b0;
      r_halt     <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_window   <= w_window_nxt;
      r_fill_cnt <= w_fill_nxt;
      r_match    <= w_match_nxt;
      r_halt     <= w_halt_nxt;
      r_count    <= w_count_nxt;
    end
  end

  assign match_flag  = r_match;
  assign halt_flag   = r_halt;
  assign match_count = r_count;

endmodule

`default_nettype wire

// File: doc/pattern_detector.md
PATTERN_DETECTOR -- requirements
Module: pattern_detector

Interface
REQ-001 Parameter WIDTH, default 8: pattern and window width in bits, minimum 2.
REQ-002 Parameter CNT_W, default 8: match counter width.
REQ-003 Parameter HALT_LIMIT, default 200: match_count value that triggers halt, range 1..2^CNT_W-1.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 data_in  input  1  serial data bit, MSB of the pattern first.
REQ-007 data_valid  input  1  data_in is valid this cycle.
REQ-008 pattern  input  WIDTH  target pattern, SHALL be held stable except during reset.
REQ-009 enable_count  input  1  count enable from the match controller.
REQ-010 ctrl_state  input  2  controller state: 00 idle, 01 match, 10 halt, 11 illegal.
REQ-011 match_flag  output  1  registered; window equals pattern.
REQ-012 halt_flag  output  1  registered; detector locked.
REQ-013 match_count  output  CNT_W  registered count of enabled valid cycles.

Function
REQ-014 The block SHALL implement FSM states FILL, SCAN and LOCKED; unused encodings SHALL go to FILL.
REQ-015 Shift: on each edge with data_valid=1 outside LOCKED, window <= {window[WIDTH-2:0], data_in}. No shift without data_valid.
REQ-016 FILL: counts valid bits; on the edge accepting the WIDTH-th valid bit, the FSM SHALL enter SCAN and evaluate match on that same edge.
REQ-017 match_flag SHALL be updated only on edges that accept a valid bit in SCAN (or the SCAN entry edge), as (new window == pattern). Latency: 1 cycle after the completing bit. It SHALL hold between valid bits and SHALL be 0 in FILL.
REQ-018 match_count SHALL increment on edges with state SCAN, enable_count=1 and data_valid=1, saturating at 2^CNT_W-1.
REQ-019 When an increment makes match_count equal HALT_LIMIT, the FSM SHALL enter LOCKED on that edge: halt_flag=1 and match_flag=0 from the next cycle.
REQ-020 If ctrl_state==11 on any edge in FILL or SCAN, the FSM SHALL enter LOCKED on that edge. This SHALL take priority over a simultaneous match or increment, and match_count SHALL not increment on that edge.
REQ-021 LOCKED: halt_flag=1, match_flag=0, window, fill counter and match_count frozen. Only reset SHALL exit LOCKED.
REQ-022 enable_count=1 while in FILL SHALL be ignored.
REQ-023 If halt and match_flag would both become 1 on one edge, halt SHALL win and match_flag SHALL be 0.

Reset
REQ-024 With reset=0 at an edge: state FILL, window 0, fill counter 0, match_flag 0, halt_flag 0, match_count 0. This SHALL override all other inputs, including in mid-stream or LOCKED.
REQ-025 After reset is released, WIDTH new valid bits SHALL be required before match_flag can assert.

Configuration
REQ-026 Macro PATTERN_MASK_EN. When defined: added input pattern_mask [WIDTH-1:0], and the match SHALL compare only bit positions where the mask bit is 1. An all-zero mask SHALL match every window in SCAN.
REQ-027 When PATTERN_MASK_EN is undefined: no pattern_mask port exists, and the match SHALL be a full WIDTH-bit equality.

Verification
REQ-028 Scenario: pattern=8'hA5, bits 1,0,1,0,0,1,0,1 with data_valid=1 -> match_flag=1 in the cycle after bit 8; next valid bit 0 -> match_flag=0.
REQ-029 Scenario: same stream with data_valid low for 3 cycles between bits 4 and 5 -> match_flag stays 0 during the gap and asserts 1 cycle after bit 8.
REQ-030 Scenario: HALT_LIMIT=4, enable_count=1, 4 valid bits in SCAN -> match_count=4 and halt_flag=1 after the 4th bit. Further bits -> all outputs frozen.
REQ-031 Scenario: ctrl_state=11 for one cycle during SCAN while the completing bit arrives -> halt_flag=1, match_flag=0, match_count unchanged.
REQ-032 Scenario: reset=0 for one cycle while in LOCKED with match_count=4 -> all outputs 0, state FILL. A full pattern is re-required before match.
REQ-033 Scenario (PATTERN_MASK_EN): pattern=8'hA5, mask=8'hF0, stream 8'hA3 -> match_flag=1. Same stream with mask=8'hFF -> match_flag=0.
